// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
//   Shared definitions for the ALU command sequencer. It holds the ALU opcodes
//   the sequencer issues by itself, the ALU error codes, the sequencer FSM
//   state encoding and a small error helper.
//   Optional macro: ALU_SEQ_ERR_HALT_EN adds the S_HALT state.
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_CLEAR = 4'b1100;  // zero the ALU accumulator
  localparam logic [3:0] OP_NOP   = 4'b1110;  // ALU feedback register holds

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_EXEC = 3'd2,
    S_RESP = 3'd3
`ifdef ALU_SEQ_ERR_HALT_EN
    , S_HALT = 3'd4
`endif
  } seq_state_t;

  // Any nonzero ALU error code counts as an error.
  function automatic logic is_error(input logic [1:0] err);
    return err != ERR_NONE;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
//   Synchronous command FIFO with registered read data.
//   Pointers carry one extra wrap bit, so full/empty come from comparing the
//   MSBs and the index bits; pointer wrap is natural binary overflow.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//     push, din     write din when push && !full
//     pop, dout     when pop && !empty, the head entry appears on dout
//                   after the same edge (registered read)
//     flush         synchronous empty
//     full, empty   status flags
module alu_cmd_fifo #(
  parameter int DW    = 68,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = dout_reg;

  // Storage and read register carry no reset so they map onto block RAM;
  // the consumer only looks at dout in the cycle after a pop.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
    if (pop_ok) begin
      dout_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command front-end for the 16-op accumulator ALU. Queues {opcode, P, Q}
//   commands, issues each to the ALU for exactly one clock and returns the
//   ALU result and error code over a valid/ready response port. Drives NO-OP
//   whenever idle, so the ALU feedback register holds its value.
//   Parameters: WIDTH (operand width), DEPTH (FIFO entries, power of two >= 2),
//               INIT_CLEAR (1: issue CLEAR for one cycle after reset release).
//   Optional macro: ALU_SEQ_ERR_HALT_EN -- after the response of a failed
//     command the sequencer halts, flushes the queue and refuses commands
//     until err_clear.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     cmd_valid/cmd_ready           command handshake, cmd_op/cmd_p/cmd_q payload
//     rsp_valid/rsp_ready           response handshake, rsp_data/rsp_err payload
//     alu_opcode/alu_p/alu_q        to the ALU
//     alu_result/alu_err            from the ALU (combinational, same cycle)
//     err_clear                     clears err_sticky (and leaves HALT)
//     err_sticky                    set on any captured nonzero alu_err
//     busy                          FSM not idle or queue not empty
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_p,
  input  logic [WIDTH-1:0] cmd_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_err,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_p,
  output logic [WIDTH-1:0] alu_q,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_err,
  input  logic             err_clear,
  output logic             err_sticky,
  output logic             busy
);

  localparam int CW = 4 + 2 * WIDTH;

  seq_state_t state_reg;
  seq_state_t state_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_din;
  logic [CW-1:0]    fifo_dout;
  logic [3:0]       exec_op;
  logic [WIDTH-1:0] exec_p;
  logic [WIDTH-1:0] exec_q;

  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [1:0]       rsp_err_reg;
  logic             err_sticky_reg;

  assign fifo_din  = {cmd_op, cmd_p, cmd_q};
  assign exec_op   = fifo_dout[CW-1 -: 4];
  assign exec_p    = fifo_dout[2*WIDTH-1 -: WIDTH];
  assign exec_q    = fifo_dout[WIDTH-1:0];
  assign fifo_push = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DW    (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and ALU/command-side outputs. The ALU drive is decoded from
  // the state register, so an asynchronous reset returns it to NO-OP at once.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    cmd_ready  = !fifo_full;
    alu_opcode = OP_NOP;
    alu_p      = '0;
    alu_q      = '0;
    case (state_reg)
      S_INIT: begin
        cmd_ready = 1'b0;
        // rst gates CLEAR so the reset value of alu_opcode stays NO-OP.
        if (INIT_CLEAR && !rst) begin
          alu_opcode = OP_CLEAR;
        end
        state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_opcode = exec_op;
        alu_p      = exec_p;
        alu_q      = exec_q;
        state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
`ifdef ALU_SEQ_ERR_HALT_EN
          if (is_error(rsp_err_reg)) begin
            state_next = S_HALT;
          end
`endif
        end
      end
`ifdef ALU_SEQ_ERR_HALT_EN
      S_HALT: begin
        cmd_ready  = 1'b0;
        fifo_flush = 1'b1;
        if (err_clear) begin
          state_next = S_IDLE;
        end
      end
`endif
      default: begin
        cmd_ready  = 1'b0;
        state_next = S_INIT;
      end
    endcase
  end

  // Response capture happens at the edge that closes the EXEC cycle, while
  // the ALU still sees the issued command on its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= ERR_NONE;
    end else if (state_reg == S_EXEC) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= alu_result;
      rsp_err_reg   <= alu_err;
    end else if (state_reg == S_RESP && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  // A new error outranks err_clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if (state_reg == S_EXEC && is_error(alu_err)) begin
      err_sticky_reg <= 1'b1;
    end else if (err_clear) begin
      err_sticky_reg <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_err    = rsp_err_reg;
  assign err_sticky = err_sticky_reg;
  assign busy       = (state_reg != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_p;
  logic [W-1:0] cmd_q;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_err;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_p;
  logic [W-1:0] alu_q;
  logic [W-1:0] alu_result;
  logic [1:0]   alu_err;
  logic         err_clear;
  logic         err_sticky;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .INIT_CLEAR(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_p      (cmd_p),
    .cmd_q      (cmd_q),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_opcode (alu_opcode),
    .alu_p      (alu_p),
    .alu_q      (alu_q),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .err_clear  (err_clear),
    .err_sticky (err_sticky),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small accumulator ALU model: result is combinational, feedback register
  // loads the result every edge (NO-OP returns it, so it holds).
  logic [W-1:0]       acc = 32'd99;
  logic signed [63:0] prod;

  always_comb begin
    alu_result = acc;
    alu_err    = 2'b00;
    prod       = '0;
    case (alu_opcode)
      4'b0000: alu_result = acc + alu_p;
      4'b0010: alu_result = alu_p + alu_q;
      4'b0011: begin
        if (alu_q == '0) alu_err = 2'b01;
        else alu_result = alu_p / alu_q;
      end
      4'b0100: alu_result = alu_p - alu_q;
      4'b0101: begin
        prod = $signed(alu_p) * $signed(alu_q);
        if (prod != {{32{prod[31]}}, prod[31:0]}) alu_err = 2'b10;
        else alu_result = prod[31:0];
      end
      4'b1100: alu_result = '0;
      default: ;
    endcase
  end

  always @(posedge clk) acc <= alu_result;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [W-1:0] p, input logic [W-1:0] q);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_p     = p;
    cmd_q     = q;
    while (!cmd_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout op=%b: cmd_ready 0, expected 1", op);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [W-1:0] ed, input logic [1:0] ee);
    int t = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"}, rsp_valid, 1'b1);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_err"}, rsp_err, ee);
    $display("rsp %s data=%08h err=%0d (expected %08h/%0d)", nm, rsp_data, rsp_err, ed, ee);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, "_drop"}, rsp_valid, 1'b0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [1:0]   e;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b1110, 32'd0,       32'd0,       32'd10,         2'b00};
    tbl[1] = '{4'b0010, 32'd100,     32'd23,      32'd123,        2'b00};
    tbl[2] = '{4'b0000, 32'd5,       32'd0,       32'd128,        2'b00};
    tbl[3] = '{4'b0100, 32'd7,       32'd10,      32'hFFFF_FFFD,  2'b00};
    tbl[4] = '{4'b1110, 32'd0,       32'd0,       32'hFFFF_FFFD,  2'b00};
    tbl[5] = '{4'b0101, 32'd6,       32'd7,       32'd42,         2'b00};
    tbl[6] = '{4'b0101, 32'h1_0000,  32'h1_0000,  32'd42,         2'b10};
    tbl[7] = '{4'b0011, 32'd84,      32'd4,       32'd21,         2'b00};
    tbl[8] = '{4'b1110, 32'd0,       32'd0,       32'd21,         2'b00};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_p     = '0;
    cmd_q     = '0;
    rsp_ready = 1'b0;
    err_clear = 1'b0;

    // 1: reset values, INIT CLEAR for one cycle, then IDLE
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", alu_opcode, 4'b1110);
    chk("rst_alu_p", alu_p, 0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_sticky", err_sticky, 1'b0);
    chk("rst_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_opcode", alu_opcode, 4'b1100);
    chk("init_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_opcode", alu_opcode, 4'b1110);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // 2: latency of a single command, 3+7
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'b0010;
    cmd_p     = 32'd3;
    cmd_q     = 32'd7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("lat_n_opcode", alu_opcode, 4'b1110);
    @(posedge clk);
    #1;
    chk("lat_exec_opcode", alu_opcode, 4'b0010);
    chk("lat_exec_p", alu_p, 32'd3);
    chk("lat_exec_q", alu_q, 32'd7);
    chk("lat_exec_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_n2_valid", rsp_valid, 1'b1);
    chk("lat_n2_opcode", alu_opcode, 4'b1110);
    get_rsp("lat", 32'd10, 2'b00);

    // table-driven single commands
    for (int i = 0; i < 9; i++) begin
      push_cmd(tbl[i].op, tbl[i].p, tbl[i].q);
      get_rsp($sformatf("tbl%0d", i), tbl[i].d, tbl[i].e);
      if (tbl[i].e != 2'b00) begin
        chk($sformatf("tbl%0d_sticky", i), err_sticky, 1'b1);
        pulse_clear();
      end
    end

    // 3: back-pressure, FIFO fills, order preserved
    for (int i = 1; i <= 5; i++) push_cmd(4'b0010, i, 10 * i);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_rsp_data", rsp_data, 32'd11);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'b0010;
    cmd_p     = 32'd500;
    cmd_q     = 32'd500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("full_hold%0d_ready", i), cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    chk("full_stable_data", rsp_data, 32'd11);
    for (int i = 1; i <= 5; i++) get_rsp($sformatf("order%0d", i), 11 * i, 2'b00);
    chk("drain_busy", busy, 1'b0);

    // 4: div0, sticky, clear alone, clear colliding with a new error
    push_cmd(4'b0011, 32'd9, 32'd0);
    get_rsp("div0a", 32'd55, 2'b01);
    chk("div0a_sticky", err_sticky, 1'b1);
    pulse_clear();
    chk("clear_sticky", err_sticky, 1'b0);
    push_cmd(4'b0011, 32'd9, 32'd0);
    @(posedge clk);
    #1;
    chk("div0b_exec_opcode", alu_opcode, 4'b0011);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("collide_sticky", err_sticky, 1'b1);
    get_rsp("div0b", 32'd55, 2'b01);
    pulse_clear();
    chk("clear2_sticky", err_sticky, 1'b0);

    // 5: error followed by queued commands
    push_cmd(4'b0011, 32'd1, 32'd0);
    push_cmd(4'b0010, 32'd1, 32'd1);
    push_cmd(4'b0010, 32'd2, 32'd2);
    push_cmd(4'b0010, 32'd3, 32'd3);
    get_rsp("q_div0", 32'd55, 2'b01);
`ifdef ALU_SEQ_ERR_HALT_EN
    @(negedge clk);
    chk("halt_cmd_ready", cmd_ready, 1'b0);
    chk("halt_busy", busy, 1'b1);
    pulse_clear();
    chk("halt_exit_busy", busy, 1'b0);
    chk("halt_exit_ready", cmd_ready, 1'b1);
`else
    get_rsp("q1", 32'd2, 2'b00);
    get_rsp("q2", 32'd4, 2'b00);
    get_rsp("q3", 32'd6, 2'b00);
    pulse_clear();
`endif

    // 6: reset during EXEC
    push_cmd(4'b0010, 32'd1000, 32'd1);
    push_cmd(4'b0010, 32'd5, 32'd5);
    chk("mid_exec_opcode", alu_opcode, 4'b0010);
    chk("mid_exec_p", alu_p, 32'd1000);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_opcode", alu_opcode, 4'b1110);
    chk("mid_rst_p", alu_p, 0);
    chk("mid_rst_q", alu_q, 0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("replay_opcode", alu_opcode, 4'b1100);
    @(posedge clk);
    #1;
    chk("replay_idle_opcode", alu_opcode, 4'b1110);
    chk("replay_flushed_busy", busy, 1'b0);
    chk("replay_ready", cmd_ready, 1'b1);
    push_cmd(4'b1110, 32'd0, 32'd0);
    get_rsp("after_clear", 32'd0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
